// File: rtl/icap_pkg.sv
// icap_pkg: shared capture-mode encoding and prescaler terminal counts
package icap_pkg;

    typedef enum logic [2:0] {
        ICM_OFF   = 3'd0,
        ICM_EVERY = 3'd1,
        ICM_FALL  = 3'd2,
        ICM_RISE  = 3'd3,
        ICM_DIV4  = 3'd4,
        ICM_DIV16 = 3'd5,
        ICM_EDGE  = 3'd6,
        ICM_WAKE  = 3'd7
    } icm_e;

    localparam logic [3:0] PS_TC_DIV4  = 4'd3;
    localparam logic [3:0] PS_TC_DIV16 = 4'd15;

endpackage

// File: rtl/icap_fifo.sv
// icap_fifo: circular capture buffer with flush and simultaneous push/pop
module icap_fifo #(
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [TW-1:0]              din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [TW-1:0]              head
);

    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, cnt_d;
    logic          empty_q, do_push, do_pop;

    assign full  = count == (AW+1)'(DEPTH);
    assign empty = empty_q;
    assign level = count;
    assign head  = empty_q ? '0 : mem[rd_ptr];

    // Qualify requests: a pop needs data, a push needs room or a same-cycle pop
    always_comb begin
        do_pop  = pop && !empty_q && !flush;
        do_push = push && (!full || do_pop) && !flush;
        cnt_d   = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer, occupancy and empty-flag registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= cnt_d;
            empty_q <= cnt_d == '0;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/icap_controller.sv
// icap_controller: prescales qualified edges, captures timer values and raises interrupts
module icap_controller
    import icap_pkg::*;
#(
    parameter int TW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [2:0]    icm_i,
    input  logic [1:0]    ici_i,
    input  logic          edge_i,
    input  logic [TW-1:0] timer_i,
    input  logic          rd_i,
    output logic [TW-1:0] buf_o,
    output logic          bne_o,
    output logic          ov_o,
    output logic          irq_o
);

    localparam int AW = $clog2(DEPTH);

    icm_e        mode, mode_q;
    logic        off, mode_chg, cap, pop_ok, push_ok, drop, irq_d, ov_d;
    logic [3:0]  pcnt_q, pcnt_d, pc_eff;
    logic [1:0]  ccnt_q, ccnt_d, cc_eff;
    logic        full, empty;
    logic [AW:0] level;

    assign mode     = icm_e'(icm_i);
    assign off      = mode == ICM_OFF;
    assign mode_chg = mode != mode_q;
    assign bne_o    = !empty;

    icap_fifo #(.TW(TW), .DEPTH(DEPTH)) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push_ok),
        .pop   (pop_ok),
        .flush (off),
        .din   (timer_i),
        .full  (full),
        .empty (empty),
        .level (level),
        .head  (buf_o)
    );

    // Prescaler, capture decision, capture counter, overflow and interrupt next-state
    always_comb begin
        pc_eff = mode_chg ? 4'd0 : pcnt_q;
        cc_eff = mode_chg ? 2'd0 : ccnt_q;
        pcnt_d = pc_eff;
        cap    = 1'b0;
        irq_d  = 1'b0;
        case (mode)
            ICM_EVERY, ICM_FALL, ICM_RISE: cap = edge_i;
            ICM_DIV4: if (edge_i) begin
                cap    = pc_eff == PS_TC_DIV4;
                pcnt_d = cap ? 4'd0 : pc_eff + 4'd1;
            end
            ICM_DIV16: if (edge_i) begin
                cap    = pc_eff == PS_TC_DIV16;
                pcnt_d = cap ? 4'd0 : pc_eff + 4'd1;
            end
            ICM_EDGE, ICM_WAKE: irq_d = edge_i;
            default: pcnt_d = 4'd0;
        endcase
        pop_ok  = rd_i && !empty && !off;
        push_ok = cap && (!full || pop_ok);
        drop    = cap && full && !pop_ok;
        ccnt_d  = off ? 2'd0 : cc_eff;
        if (push_ok) begin
            irq_d  = cc_eff == ici_i;
            ccnt_d = (cc_eff == ici_i) ? 2'd0 : cc_eff + 2'd1;
        end
        ov_d = off ? 1'b0 :
               drop ? 1'b1 :
               (pop_ok && !push_ok && level == (AW+1)'(1)) ? 1'b0 : ov_o;
    end

    // Mode, prescaler, capture count and status registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q <= ICM_OFF;
            pcnt_q <= '0;
            ccnt_q <= '0;
            ov_o   <= 1'b0;
            irq_o  <= 1'b0;
        end else begin
            mode_q <= mode;
            pcnt_q <= pcnt_d;
            ccnt_q <= ccnt_d;
            ov_o   <= ov_d;
            irq_o  <= irq_d;
        end
    end

endmodule

// File: tb/tb_icap_controller.sv
// tb_icap_controller: directed checks of capture, prescale, irq, overflow, flush and reset
module tb_icap_controller;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  icm_i = 3'd0;
    logic [1:0]  ici_i = 2'd0;
    logic        edge_i = 1'b0;
    logic [15:0] timer_i = 16'h0;
    logic        rd_i = 1'b0;
    logic [15:0] buf_o;
    logic        bne_o, ov_o, irq_o;
    int          total = 0;
    int          bad = 0;

    icap_controller #(.TW(16), .DEPTH(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .icm_i   (icm_i),
        .ici_i   (ici_i),
        .edge_i  (edge_i),
        .timer_i (timer_i),
        .rd_i    (rd_i),
        .buf_o   (buf_o),
        .bne_o   (bne_o),
        .ov_o    (ov_o),
        .irq_o   (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse(input logic [15:0] t);
        edge_i  = 1'b1;
        timer_i = t;
        tick();
        edge_i  = 1'b0;
    endtask

    task automatic pop();
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_buf", 32'(buf_o), 0);
        chk("rst_bne", 32'(bne_o), 0);
        chk("rst_ov", 32'(ov_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        tick();
        rst_i = 1'b0;

        icm_i = 3'd1; ici_i = 2'd0;
        tick();
        pulse(16'h0010);
        chk("m1_bne", 32'(bne_o), 1);
        chk("m1_buf0", 32'(buf_o), 32'h10);
        chk("m1_irq0", 32'(irq_o), 1);
        tick();
        chk("m1_irq_drop", 32'(irq_o), 0);
        pulse(16'h0025);
        chk("m1_irq1", 32'(irq_o), 1);
        chk("m1_head", 32'(buf_o), 32'h10);
        pop();
        chk("m1_pop1", 32'(buf_o), 32'h25);
        pop();
        chk("m1_pop2_bne", 32'(bne_o), 0);
        chk("m1_pop2_buf", 32'(buf_o), 0);
        pop();
        chk("m1_empty_rd", 32'(bne_o), 0);

        icm_i = 3'd4;
        tick();
        for (int i = 1; i <= 8; i++) begin
            pulse(16'h0100 + 16'(i));
            if (i == 3) chk("d4_none_yet", 32'(bne_o), 0);
            if (i == 4) chk("d4_irq", 32'(irq_o), 1);
            tick();
        end
        chk("d4_first", 32'(buf_o), 32'h104);
        pop();
        chk("d4_second", 32'(buf_o), 32'h108);
        pop();
        chk("d4_two_only", 32'(bne_o), 0);

        icm_i = 3'd5;
        tick();
        for (int i = 1; i <= 16; i++) begin
            pulse(16'h0200 + 16'(i));
            if (i == 15) chk("d16_none_yet", 32'(bne_o), 0);
        end
        chk("d16_cap", 32'(buf_o), 32'h210);
        pop();
        chk("d16_one_only", 32'(bne_o), 0);

        icm_i = 3'd1; ici_i = 2'd3;
        tick();
        for (int i = 1; i <= 5; i++) begin
            pulse(16'h0300 + 16'(i));
            chk($sformatf("ici3_irq%0d", i), 32'(irq_o), (i == 4) ? 1 : 0);
        end
        chk("ovf_set", 32'(ov_o), 1);
        chk("ovf_head", 32'(buf_o), 32'h301);
        pop();
        chk("ovf_sticky", 32'(ov_o), 1);
        chk("ovf_next", 32'(buf_o), 32'h302);
        pop(); pop(); pop();
        chk("ovf_clear", 32'(ov_o), 0);
        chk("ovf_empty", 32'(bne_o), 0);

        for (int i = 1; i <= 4; i++) pulse(16'h0400 + 16'(i));
        chk("full_irq", 32'(irq_o), 1);
        rd_i = 1'b1;
        pulse(16'h0405);
        rd_i = 1'b0;
        chk("simul_ov", 32'(ov_o), 0);
        chk("simul_irq", 32'(irq_o), 0);
        chk("simul_head", 32'(buf_o), 32'h402);
        pop();
        chk("simul_e3", 32'(buf_o), 32'h403);
        pop();
        chk("simul_e4", 32'(buf_o), 32'h404);
        pop();
        chk("simul_tail", 32'(buf_o), 32'h405);
        pop();
        chk("simul_drained", 32'(bne_o), 0);

        icm_i = 3'd6;
        tick();
        pulse(16'h0555);
        chk("m6_irq", 32'(irq_o), 1);
        chk("m6_nocap", 32'(bne_o), 0);

        icm_i = 3'd4; ici_i = 2'd0;
        tick();
        pulse(16'h0501); pulse(16'h0502);
        icm_i = 3'd5;
        tick();
        for (int i = 1; i <= 16; i++) begin
            pulse(16'h0510 + 16'(i));
            if (i == 15) chk("sw_none_yet", 32'(bne_o), 0);
        end
        chk("sw_cap", 32'(buf_o), 32'h520);
        icm_i = 3'd1;
        tick();
        for (int i = 1; i <= 4; i++) pulse(16'h0530 + 16'(i));
        chk("off_pre_ov", 32'(ov_o), 1);
        icm_i = 3'd0;
        tick();
        chk("off_ov", 32'(ov_o), 0);
        chk("off_bne", 32'(bne_o), 0);
        chk("off_buf", 32'(buf_o), 0);

        icm_i = 3'd1;
        tick();
        for (int i = 1; i <= 3; i++) pulse(16'h0600 + 16'(i));
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_buf", 32'(buf_o), 0);
        chk("arst_bne", 32'(bne_o), 0);
        chk("arst_irq", 32'(irq_o), 0);
        #1;
        rst_i = 1'b0;
        pulse(16'h06AA);
        chk("post_rst_buf", 32'(buf_o), 32'h6AA);
        chk("post_rst_bne", 32'(bne_o), 1);
        pop();
        chk("post_rst_single", 32'(bne_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
